mem_arbiter: RTL and testbench

//  Two-requester round-robin arbiter in front of the single-port SRAM (memory). Accepts valid/ready

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arbiter_if.sv | 55 +++++
 rtl/mem_arbiter_rr_arb2.sv | 36 +++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester SRAM arbiter.
// Contents: default WIDTH/DEPTH/TIMEOUT, FSM state encodings, requester id type.
package mem_arb_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_DEPTH   = 64;
    localparam int DEF_TIMEOUT = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef logic req_id_t;
    localparam req_id_t ID_M0 = 1'b0;
    localparam req_id_t ID_M1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the single-port SRAM.
// Ports (signal groups):
//   m0_* / m1_*  requester command (valid, wr_rd, addr, wdata) and response (ready, rdata)
//   mem_*        memory command (valid, wr_rd, addr, wdata) and response (ready, rdata)
//   err_o        sticky watchdog flag, resp_err_o flags an aborted transfer's ready pulse
// Modports: slave = arbiter view, master = environment (requesters + memory) view.
interface mem_arbiter_if #(
    parameter int WIDTH     = 16,
    parameter int ADDR_SIZE = 6
);
    logic                 m0_valid_i;
    logic                 m0_wr_rd_i;
    logic [ADDR_SIZE-1:0] m0_addr_i;
    logic [WIDTH-1:0]     m0_wdata_i;
    logic                 m0_ready_o;
    logic [WIDTH-1:0]     m0_rdata_o;

    logic                 m1_valid_i;
    logic                 m1_wr_rd_i;
    logic [ADDR_SIZE-1:0] m1_addr_i;
    logic [WIDTH-1:0]     m1_wdata_i;
    logic                 m1_ready_o;
    logic [WIDTH-1:0]     m1_rdata_o;

    logic                 mem_valid_o;
    logic                 mem_wr_rd_o;
    logic [ADDR_SIZE-1:0] mem_addr_o;
    logic [WIDTH-1:0]     mem_wdata_o;
    logic                 mem_ready_i;
    logic [WIDTH-1:0]     mem_rdata_i;

    logic                 err_o;
    logic                 resp_err_o;

    modport slave (
        input  m0_valid_i, m0_wr_rd_i, m0_addr_i, m0_wdata_i,
        output m0_ready_o, m0_rdata_o,
        input  m1_valid_i, m1_wr_rd_i, m1_addr_i, m1_wdata_i,
        output m1_ready_o, m1_rdata_o,
        output mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o,
        input  mem_ready_i, mem_rdata_i,
        output err_o, resp_err_o
    );

    modport master (
        output m0_valid_i, m0_wr_rd_i, m0_addr_i, m0_wdata_i,
        input  m0_ready_o, m0_rdata_o,
        output m1_valid_i, m1_wr_rd_i, m1_addr_i, m1_wdata_i,
        input  m1_ready_o, m1_rdata_o,
        input  mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o,
        output mem_ready_i, mem_rdata_i,
        input  err_o, resp_err_o
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant with a single priority pointer.
// Ports:
//   clk_i, rst_i  clock and asynchronous active-low reset
//   req[1:0]      request vector, bit 0 = m0, bit 1 = m1
//   advance       a grant is being taken this cycle
//   gnt[1:0]      one-hot grant (all zero with no request)
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    // ptr_q = 0 prefers m0, 1 prefers m1; only consulted on a contested request
    logic ptr_q;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // After a contested grant the loser gets priority next time
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr_q <= 1'b0;
        end else if (advance && (req == 2'b11)) begin
            ptr_q <= ~ptr_q;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter placing one m0/m1 command at a time on a single-port SRAM,
// with a watchdog that aborts transfers the memory never acknowledges.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-low reset
//   bus     mem_arbiter_if.slave: requester handshakes, memory port, err_o/resp_err_o
//
// state   | meaning
// IDLE    | waiting for a requester valid; winner's command latched on exit
// WAIT    | latched command on the memory port, watchdog counting
// RESP    | one-cycle ready pulse (with rdata / resp_err) to the winner
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mem_arbiter_if.slave bus
);
    localparam int ADDR_SIZE = $clog2(DEPTH);
    localparam int WD_W      = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [1:0]           state_q;
    req_id_t              cmd_id_q;
    logic                 cmd_wr_q;
    logic [ADDR_SIZE-1:0] cmd_addr_q;
    logic [WIDTH-1:0]     cmd_wdata_q;
    logic [WIDTH-1:0]     rdata_q;
    logic                 abort_q;
    logic                 err_q;
    logic [WD_W-1:0]      wd_q;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       advance;
    logic       in_wait;
    logic       in_resp;

    assign req     = {bus.m1_valid_i, bus.m0_valid_i};
    assign advance = (state_q == ST_IDLE) && (req != 2'b00);
    assign in_wait = (state_q == ST_WAIT);
    assign in_resp = (state_q == ST_RESP);

    rr_arb2 u_rr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     (req),
        .advance (advance),
        .gnt     (gnt)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            cmd_id_q    <= ID_M0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rdata_q     <= '0;
            abort_q     <= 1'b0;
            err_q       <= 1'b0;
            wd_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (advance) begin
                        cmd_id_q <= gnt[1];
                        if (gnt[0]) begin
                            cmd_wr_q    <= bus.m0_wr_rd_i;
                            cmd_addr_q  <= bus.m0_addr_i;
                            cmd_wdata_q <= bus.m0_wdata_i;
                        end else begin
                            cmd_wr_q    <= bus.m1_wr_rd_i;
                            cmd_addr_q  <= bus.m1_addr_i;
                            cmd_wdata_q <= bus.m1_wdata_i;
                        end
                        wd_q    <= '0;
                        abort_q <= 1'b0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // An ack arriving on the last watchdog cycle still completes normally
                    if (bus.mem_ready_i) begin
                        rdata_q <= bus.mem_rdata_i;
                        state_q <= ST_RESP;
                    end else if (wd_q == WD_LAST) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        abort_q <= 1'b1;
                        state_q <= ST_RESP;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Memory port is forced to zero outside WAIT so stale commands never leak out
    assign bus.mem_valid_o = in_wait;
    assign bus.mem_wr_rd_o = in_wait & cmd_wr_q;
    assign bus.mem_addr_o  = in_wait ? cmd_addr_q : '0;
    assign bus.mem_wdata_o = in_wait ? cmd_wdata_q : '0;

    assign bus.m0_ready_o = in_resp && (cmd_id_q == ID_M0);
    assign bus.m1_ready_o = in_resp && (cmd_id_q == ID_M1);
    assign bus.m0_rdata_o = (bus.m0_ready_o && !cmd_wr_q) ? rdata_q : '0;
    assign bus.m1_rdata_o = (bus.m1_ready_o && !cmd_wr_q) ? rdata_q : '0;

    assign bus.err_o      = err_q;
    assign bus.resp_err_o = in_resp & abort_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requester sequences push expected
// transfers; a monitor checks the memory port and every ready pulse against them.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int WIDTH     = 16;
    localparam int DEPTH     = 64;
    localparam int TIMEOUT   = 32;
    localparam int ADDR_SIZE = 6;

    typedef struct {
        logic                 id;
        logic                 wr;
        logic [ADDR_SIZE-1:0] addr;
        logic [WIDTH-1:0]     wdata;
        logic [WIDTH-1:0]     rdata;
        logic                 err;
        int                   lat;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    mem_arbiter_if #(.WIDTH(WIDTH), .ADDR_SIZE(ADDR_SIZE)) bus ();

    mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [WIDTH-1:0] mem [DEPTH];
    int mem_delay = 1;
    bit mem_stuck = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    task automatic push(input logic id, input logic wr, input logic [ADDR_SIZE-1:0] addr,
                        input logic [WIDTH-1:0] wdata, input logic [WIDTH-1:0] rdata,
                        input logic err, input int lat);
        exp_t e;
        e.id = id; e.wr = wr; e.addr = addr; e.wdata = wdata;
        e.rdata = rdata; e.err = err; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic id, input logic wr, input logic [ADDR_SIZE-1:0] addr,
                         input logic [WIDTH-1:0] wdata);
        if (id == 1'b0) begin
            bus.m0_valid_i = 1'b1; bus.m0_wr_rd_i = wr;
            bus.m0_addr_i  = addr; bus.m0_wdata_i = wdata;
        end else begin
            bus.m1_valid_i = 1'b1; bus.m1_wr_rd_i = wr;
            bus.m1_addr_i  = addr; bus.m1_wdata_i = wdata;
        end
    endtask

    task automatic drop(input logic id);
        if (id == 1'b0) bus.m0_valid_i = 1'b0;
        else            bus.m1_valid_i = 1'b0;
    endtask

    task automatic wait_ready(input logic id, input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(posedge clk_i); #1;
            seen = (id == 1'b0) ? bus.m0_ready_o : bus.m1_ready_o;
        end
        if (!seen) flag({name, "_ready_timeout"});
    endtask

    task automatic wait_mem_valid(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge clk_i); #1;
            seen = bus.mem_valid_o;
        end
        if (!seen) flag({name, "_mem_valid_timeout"});
    endtask

    // Memory model: acks mem_delay cycles into WAIT, never when stuck
    initial begin
        int mcnt;
        mcnt = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = '0;
        forever begin
            @(posedge clk_i); #1;
            if (!rst_i || !bus.mem_valid_o) begin
                bus.mem_ready_i = 1'b0;
                bus.mem_rdata_i = '0;
                mcnt = 0;
            end else begin
                mcnt++;
                if (!mem_stuck && mcnt >= mem_delay) begin
                    bus.mem_ready_i = 1'b1;
                    if (bus.mem_wr_rd_o) mem[bus.mem_addr_o] = bus.mem_wdata_o;
                    else                 bus.mem_rdata_i = mem[bus.mem_addr_o];
                end
            end
        end
    end

    // Monitor: memory port must carry the head command; ready pulses pop and compare
    initial begin
        int   cyc;
        int   start;
        bit   prev_v;
        exp_t e;
        cyc = 0; start = 0; prev_v = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            cyc++;
            check("ready_overlap", {31'd0, bus.m0_ready_o & bus.m1_ready_o}, 32'd0);
            if (!bus.m0_ready_o) check("m0_rdata_idle", {16'd0, bus.m0_rdata_o}, 32'd0);
            if (!bus.m1_ready_o) check("m1_rdata_idle", {16'd0, bus.m1_rdata_o}, 32'd0);
            if (bus.mem_valid_o) begin
                if (!prev_v) start = cyc;
                if (exp_q.size() == 0) begin
                    flag("unexpected_mem_valid");
                end else begin
                    e = exp_q[0];
                    check("mem_wr_rd", {31'd0, bus.mem_wr_rd_o}, {31'd0, e.wr});
                    check("mem_addr", {26'd0, bus.mem_addr_o}, {26'd0, e.addr});
                    if (e.wr) check("mem_wdata", {16'd0, bus.mem_wdata_o}, {16'd0, e.wdata});
                end
            end
            prev_v = bus.mem_valid_o;
            if (bus.m0_ready_o || bus.m1_ready_o) begin
                if (exp_q.size() == 0) begin
                    flag("unexpected_ready");
                end else begin
                    e = exp_q.pop_front();
                    check("resp_id", {31'd0, bus.m1_ready_o}, {31'd0, e.id});
                    check("resp_rdata",
                          {16'd0, (bus.m1_ready_o ? bus.m1_rdata_o : bus.m0_rdata_o)},
                          {16'd0, e.rdata});
                    check("resp_err", {31'd0, bus.resp_err_o}, {31'd0, e.err});
                    if (e.lat > 0) check("latency", cyc - (start - 1), e.lat);
                end
            end else begin
                check("resp_err_idle", {31'd0, bus.resp_err_o}, 32'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        bus.m0_valid_i = 1'b0; bus.m0_wr_rd_i = 1'b0; bus.m0_addr_i = '0; bus.m0_wdata_i = '0;
        bus.m1_valid_i = 1'b0; bus.m1_wr_rd_i = 1'b0; bus.m1_addr_i = '0; bus.m1_wdata_i = '0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_mem_valid", {31'd0, bus.mem_valid_o}, 32'd0);
        check("rst_mem_cmd", {bus.mem_wr_rd_o, bus.mem_addr_o, bus.mem_wdata_o}, 32'd0);
        check("rst_ready", {30'd0, bus.m0_ready_o, bus.m1_ready_o}, 32'd0);
        check("rst_err", {30'd0, bus.err_o, bus.resp_err_o}, 32'd0);
        @(negedge clk_i) rst_i = 1'b1;

        // Contested first request after reset: m0 wins
        mem_delay = 1;
        push(1'b0, 1'b1, 6'd1, 16'h1111, 16'h0, 1'b0, 2);
        push(1'b1, 1'b1, 6'd2, 16'h2222, 16'h0, 1'b0, 2);
        fork
            begin issue(1'b0, 1'b1, 6'd1, 16'h1111); wait_ready(1'b0, "t1_m0"); drop(1'b0); end
            begin issue(1'b1, 1'b1, 6'd2, 16'h2222); wait_ready(1'b1, "t1_m1"); drop(1'b1); end
        join

        // m0 writes A5A5 to 5, m1 reads it back
        mem_delay = 2;
        push(1'b0, 1'b1, 6'd5, 16'hA5A5, 16'h0, 1'b0, 3);
        issue(1'b0, 1'b1, 6'd5, 16'hA5A5); wait_ready(1'b0, "t2_wr"); drop(1'b0);
        mem_delay = 3;
        push(1'b1, 1'b0, 6'd5, 16'h0, 16'hA5A5, 1'b0, 4);
        issue(1'b1, 1'b0, 6'd5, 16'h0); wait_ready(1'b1, "t2_rd"); drop(1'b1);

        // Both held valid for six transfers: strict alternation from m0
        @(negedge clk_i) rst_i = 1'b0;
        @(negedge clk_i) rst_i = 1'b1;
        mem_delay = 1;
        push(1'b0, 1'b1, 6'd20, 16'h0100, 16'h0,    1'b0, 2);
        push(1'b1, 1'b0, 6'd1,  16'h0,    16'h1111, 1'b0, 2);
        push(1'b0, 1'b1, 6'd21, 16'h0101, 16'h0,    1'b0, 2);
        push(1'b1, 1'b0, 6'd2,  16'h0,    16'h2222, 1'b0, 2);
        push(1'b0, 1'b1, 6'd22, 16'h0102, 16'h0,    1'b0, 2);
        push(1'b1, 1'b0, 6'd5,  16'h0,    16'hA5A5, 1'b0, 2);
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    issue(1'b0, 1'b1, 6'(20 + i), 16'(16'h0100 + i));
                    wait_ready(1'b0, "t3_m0");
                end
                drop(1'b0);
            end
            begin
                for (int j = 0; j < 3; j++) begin
                    issue(1'b1, 1'b0, (j == 0) ? 6'd1 : (j == 1) ? 6'd2 : 6'd5, 16'h0);
                    wait_ready(1'b1, "t3_m1");
                end
                drop(1'b1);
            end
        join

        // m1 changes its command mid-WAIT; memory port keeps the latched one
        mem_delay = 3;
        push(1'b1, 1'b1, 6'd10, 16'hBEEF, 16'h0, 1'b0, 4);
        issue(1'b1, 1'b1, 6'd10, 16'hBEEF);
        wait_mem_valid("t4");
        issue(1'b1, 1'b1, 6'd33, 16'h1234);
        wait_ready(1'b1, "t4_wr"); drop(1'b1);
        push(1'b0, 1'b0, 6'd10, 16'h0, 16'hBEEF, 1'b0, 4);
        issue(1'b0, 1'b0, 6'd10, 16'h0); wait_ready(1'b0, "t4_rd10"); drop(1'b0);
        push(1'b0, 1'b0, 6'd33, 16'h0, 16'h0, 1'b0, 4);
        issue(1'b0, 1'b0, 6'd33, 16'h0); wait_ready(1'b0, "t4_rd33"); drop(1'b0);

        // Ack on the final watchdog cycle completes normally
        mem_delay = 32;
        push(1'b0, 1'b0, 6'd5, 16'h0, 16'hA5A5, 1'b0, 33);
        issue(1'b0, 1'b0, 6'd5, 16'h0); wait_ready(1'b0, "t5_edge"); drop(1'b0);
        #1;
        check("err_after_late_ack", {31'd0, bus.err_o}, 32'd0);

        // Stuck memory: abort after 33 cycles, sticky err, then a clean transfer
        mem_stuck = 1'b1;
        push(1'b0, 1'b0, 6'd20, 16'h0, 16'h0, 1'b1, 33);
        issue(1'b0, 1'b0, 6'd20, 16'h0); wait_ready(1'b0, "t5_stuck"); drop(1'b0);
        mem_stuck = 1'b0;
        @(posedge clk_i); #1;
        check("err_sticky_1", {31'd0, bus.err_o}, 32'd1);
        mem_delay = 2;
        push(1'b1, 1'b0, 6'd21, 16'h0, 16'h0101, 1'b0, 3);
        issue(1'b1, 1'b0, 6'd21, 16'h0); wait_ready(1'b1, "t5_next"); drop(1'b1);
        @(posedge clk_i); #1;
        check("err_sticky_2", {31'd0, bus.err_o}, 32'd1);

        // Reset during WAIT: immediate drop, no ready, then clean re-arbitration
        mem_delay = 3;
        push(1'b0, 1'b0, 6'd5, 16'h0, 16'hA5A5, 1'b0, 4);
        issue(1'b0, 1'b0, 6'd5, 16'h0);
        wait_mem_valid("t6");
        #2 rst_i = 1'b0;
        #1;
        check("t6_mem_valid_drop", {31'd0, bus.mem_valid_o}, 32'd0);
        check("t6_no_ready", {30'd0, bus.m0_ready_o, bus.m1_ready_o}, 32'd0);
        check("t6_err_cleared", {31'd0, bus.err_o}, 32'd0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        repeat (3) @(posedge clk_i);
        push(1'b0, 1'b0, 6'd5, 16'h0, 16'hA5A5, 1'b0, 4);
        @(negedge clk_i) rst_i = 1'b1;
        wait_ready(1'b0, "t6_retry"); drop(1'b0);

        repeat (4) @(posedge clk_i);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
